// File: rtl/sum_pkg.sv
// ============================================================================
// Module  : sum_pkg
// Brief   : Shared opcode type and default widths for the sum_pipe datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sum_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int SUM_BUS_WIDTH_DEF  = 32;
    localparam int SUM_LANE_WIDTH_DEF = 8;

endpackage

`default_nettype wire

// File: rtl/sum_pipe_lane.sv
// ============================================================================
// Module  : sum_pipe_lane
// Brief   : One pipeline stage: LANE_WIDTH-bit add with registered sum,
//           carry-out and valid, all advancing only when en is high.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sum_pipe_lane
    import sum_pkg::*;
#(
    parameter int LANE_WIDTH = SUM_LANE_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  en,
    input  logic [LANE_WIDTH-1:0] a,
    input  logic [LANE_WIDTH-1:0] b,
    input  logic                  cin,
    input  logic                  valid_in,
    output logic [LANE_WIDTH-1:0] sum,
    output logic                  cout,
    output logic                  valid
);

    logic [LANE_WIDTH:0]   w_total;
    logic [LANE_WIDTH-1:0] r_sum;
    logic                  r_cout;
    logic                  r_valid;

    assign w_total = {1'b0, a} + {1'b0, b} + {{LANE_WIDTH{1'b0}}, cin};

    always_ff @(posedge clk) begin
        if (arst) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else if (en) begin
            r_sum   <= w_total[LANE_WIDTH-1:0];
            r_cout  <= w_total[LANE_WIDTH];
            r_valid <= valid_in;
        end
    end

    assign sum   = r_sum;
    assign cout  = r_cout;
    assign valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/sum_pipe.sv
// ============================================================================
// Module  : sum_pipe
// Brief   : Lane-pipelined adder/subtractor with valid/ready backpressure.
//           Optional signed-overflow output under macro SUM_PIPE_OVF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sum_pipe
    import sum_pkg::*;
#(
    parameter int BUS_WIDTH  = SUM_BUS_WIDTH_DEF,
    parameter int LANE_WIDTH = SUM_LANE_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [BUS_WIDTH-1:0] sum_in1,
    input  logic [BUS_WIDTH-1:0] sum_in2,
    input  logic                 sum_in_carry,
    input  logic                 sum_in_op,
    input  logic                 sum_in_en,
    output logic                 sum_in_ready,
    output logic [BUS_WIDTH-1:0] sum_out,
    output logic                 sum_out_carry,
`ifdef SUM_PIPE_OVF_EN
    output logic                 sum_out_ovf,
`endif
    output logic                 sum_out_en,
    input  logic                 sum_out_ready
);

    localparam int STAGES = BUS_WIDTH / LANE_WIDTH;

    if ((BUS_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lane_width
        $error("sum_pipe: LANE_WIDTH must divide BUS_WIDTH");
    end

    logic                  w_adv;
    logic                  w_sub;
    logic [BUS_WIDTH-1:0]  w_b_eff;
    logic                  w_cin_eff;
    logic [LANE_WIDTH-1:0] w_lane_a    [STAGES];
    logic [LANE_WIDTH-1:0] w_lane_b    [STAGES];
    logic [LANE_WIDTH-1:0] w_lane_sum  [STAGES];
    logic                  w_lane_cin  [STAGES];
    logic                  w_lane_cout [STAGES];
    logic                  w_lane_vin  [STAGES];
    logic                  w_lane_vout [STAGES];

    assign w_adv        = !sum_out_en || sum_out_ready;
    assign sum_in_ready = w_adv;

    // Subtraction becomes A + ~B + !cin here so no later stage needs the op.
    assign w_sub     = (op_e'(sum_in_op) == OP_SUB);
    assign w_b_eff   = w_sub ? ~sum_in2 : sum_in2;
    assign w_cin_eff = w_sub ? ~sum_in_carry : sum_in_carry;

    assign w_lane_a[0]   = sum_in1[LANE_WIDTH-1:0];
    assign w_lane_b[0]   = w_b_eff[LANE_WIDTH-1:0];
    assign w_lane_cin[0] = w_cin_eff;
    assign w_lane_vin[0] = sum_in_en;

    // Operand skew: each register holds the lanes not yet consumed, lowest
    // pending lane in the LSBs, shrinking by one lane per stage.
    for (genvar s = 0; s < STAGES - 1; s++) begin : g_skew
        localparam int W = BUS_WIDTH - (s + 1) * LANE_WIDTH;
        logic [W-1:0] r_a;
        logic [W-1:0] r_b;

        if (s == 0) begin : g_src_in
            always_ff @(posedge clk) begin
                if (w_adv) begin
                    r_a <= sum_in1[BUS_WIDTH-1:LANE_WIDTH];
                    r_b <= w_b_eff[BUS_WIDTH-1:LANE_WIDTH];
                end
            end
        end else begin : g_src_skew
            always_ff @(posedge clk) begin
                if (w_adv) begin
                    r_a <= g_skew[s-1].r_a[W+LANE_WIDTH-1:LANE_WIDTH];
                    r_b <= g_skew[s-1].r_b[W+LANE_WIDTH-1:LANE_WIDTH];
                end
            end
        end

        assign w_lane_a[s+1] = r_a[LANE_WIDTH-1:0];
        assign w_lane_b[s+1] = r_b[LANE_WIDTH-1:0];
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_lane
        if (s > 0) begin : g_chain
            assign w_lane_cin[s] = w_lane_cout[s-1];
            assign w_lane_vin[s] = w_lane_vout[s-1];
        end

        sum_pipe_lane #(
            .LANE_WIDTH (LANE_WIDTH)
        ) u_lane (
            .clk      (clk),
            .arst     (arst),
            .en       (w_adv),
            .a        (w_lane_a[s]),
            .b        (w_lane_b[s]),
            .cin      (w_lane_cin[s]),
            .valid_in (w_lane_vin[s]),
            .sum      (w_lane_sum[s]),
            .cout     (w_lane_cout[s]),
            .valid    (w_lane_vout[s])
        );
    end

    // Result deskew: completed lanes accumulate so they leave with the MSB lane.
    for (genvar s = 1; s < STAGES; s++) begin : g_res
        logic [s*LANE_WIDTH-1:0] r_res;

        if (s == 1) begin : g_first
            always_ff @(posedge clk) begin
                if (arst) begin
                    r_res <= '0;
                end else if (w_adv) begin
                    r_res <= w_lane_sum[0];
                end
            end
        end else begin : g_more
            always_ff @(posedge clk) begin
                if (arst) begin
                    r_res <= '0;
                end else if (w_adv) begin
                    r_res <= {w_lane_sum[s-1], g_res[s-1].r_res};
                end
            end
        end
    end

    if (STAGES == 1) begin : g_out_single
        assign sum_out = w_lane_sum[0];
    end else begin : g_out_multi
        assign sum_out = {w_lane_sum[STAGES-1], g_res[STAGES-1].r_res};
    end

    assign sum_out_carry = w_lane_cout[STAGES-1];
    assign sum_out_en    = w_lane_vout[STAGES-1];

`ifdef SUM_PIPE_OVF_EN
    // Carry into the MSB is a^b^sum at that bit; register a^b alongside the
    // final lane and recombine with its registered sum bit.
    logic r_msb_ab;

    always_ff @(posedge clk) begin
        if (arst) begin
            r_msb_ab <= 1'b0;
        end else if (w_adv) begin
            r_msb_ab <= w_lane_a[STAGES-1][LANE_WIDTH-1] ^ w_lane_b[STAGES-1][LANE_WIDTH-1];
        end
    end

    assign sum_out_ovf = r_msb_ab ^ sum_out[BUS_WIDTH-1] ^ sum_out_carry;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sum_pipe.sv
// ============================================================================
// Module  : tb_sum_pipe
// Brief   : Scoreboard bench for sum_pipe (32-bit bus, 8-bit lanes).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sum_pipe;

    localparam int W = 32;
    localparam int L = 8;
    localparam int S = W / L;

    logic         clk = 1'b0;
    logic         arst;
    logic [W-1:0] sum_in1;
    logic [W-1:0] sum_in2;
    logic         sum_in_carry;
    logic         sum_in_op;
    logic         sum_in_en;
    logic         sum_in_ready;
    logic [W-1:0] sum_out;
    logic         sum_out_carry;
`ifdef SUM_PIPE_OVF_EN
    logic         sum_out_ovf;
`endif
    logic         sum_out_en;
    logic         sum_out_ready;

    always #5 clk = ~clk;

    sum_pipe #(
        .BUS_WIDTH  (W),
        .LANE_WIDTH (L)
    ) dut (
        .clk           (clk),
        .arst          (arst),
        .sum_in1       (sum_in1),
        .sum_in2       (sum_in2),
        .sum_in_carry  (sum_in_carry),
        .sum_in_op     (sum_in_op),
        .sum_in_en     (sum_in_en),
        .sum_in_ready  (sum_in_ready),
        .sum_out       (sum_out),
        .sum_out_carry (sum_out_carry),
`ifdef SUM_PIPE_OVF_EN
        .sum_out_ovf   (sum_out_ovf),
`endif
        .sum_out_en    (sum_out_en),
        .sum_out_ready (sum_out_ready)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
        int           c0;
        bit           lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic op);
        exp_t         r;
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   full;
        bb     = op ? ~b : b;
        cc     = op ? ~cin : cin;
        full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
        r.sum   = full[W-1:0];
        r.carry = full[W];
        r.ovf   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        r.c0    = 0;
        r.lat   = 1'b0;
        return r;
    endfunction

    // Monitor: samples just after the falling edge, when inputs and outputs are settled.
    logic [W-1:0] p_sum;
    logic         p_carry;
    logic         p_stall = 1'b0;

    always @(negedge clk) begin : mon
        exp_t e;
        #1;
        if (p_stall) begin
            chk("hold_sum", sum_out, p_sum);
            chk("hold_carry", sum_out_carry, p_carry);
            chk("hold_en", sum_out_en, 1'b1);
        end
        p_stall <= (sum_out_en === 1'b1) && (sum_out_ready === 1'b0);
        p_sum   <= sum_out;
        p_carry <= sum_out_carry;
        if (sum_out_en === 1'b1 && sum_out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_out", sum_out_en, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("sum", sum_out, e.sum);
                chk("carry", sum_out_carry, e.carry);
`ifdef SUM_PIPE_OVF_EN
                chk("ovf", sum_out_ovf, e.ovf);
`endif
                if (e.lat) chk("latency", cyc - e.c0, S);
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic op, input bit lat);
        exp_t e;
        int   waits = 0;
        sum_in1      = a;
        sum_in2      = b;
        sum_in_carry = cin;
        sum_in_op    = op;
        sum_in_en    = 1'b1;
        #1;
        while (sum_in_ready !== 1'b1) begin
            if (waits >= 50) begin
                chk("accept_timeout", sum_in_ready, 1'b1);
                sum_in_en = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
            waits++;
        end
        e     = model(a, b, cin, op);
        e.c0  = cyc;
        e.lat = lat;
        sb.push_back(e);
        @(negedge clk);
        sum_in_en = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Reset with valid data on the inputs: none of it may be accepted.
        arst          = 1'b1;
        sum_in1       = 32'h1234_5678;
        sum_in2       = 32'h0F0F_0F0F;
        sum_in_carry  = 1'b1;
        sum_in_op     = 1'b0;
        sum_in_en     = 1'b1;
        sum_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        arst      = 1'b0;
        sum_in_en = 1'b0;
        #1;
        chk("rst_out_en", sum_out_en, 1'b0);
        chk("rst_sum", sum_out, 32'h0);
        chk("rst_carry", sum_out_carry, 1'b0);
        chk("rst_in_ready", sum_in_ready, 1'b1);
`ifdef SUM_PIPE_OVF_EN
        chk("rst_ovf", sum_out_ovf, 1'b0);
`endif
        repeat (8) begin
            @(negedge clk);
            #1;
            chk("rst_quiet", sum_out_en, 1'b0);
        end
        @(negedge clk);

        // Carry ripple across every lane, overflow and subtraction corners.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        send(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        send(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 1'b1);
        send(32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 1'b1);
        drain();

        // Back-to-back random traffic with a 3-cycle downstream stall.
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'b0);
            end
            begin
                repeat (6) @(negedge clk);
                sum_out_ready = 1'b0;
                repeat (3) begin
                    #1;
                    chk("in_ready_stall", sum_in_ready, 1'b0);
                    @(negedge clk);
                end
                sum_out_ready = 1'b1;
            end
        join
        drain();

        // Reset in flight: accepted tokens are discarded, pipeline restarts cleanly.
        send(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0033, 32'h0000_0044, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0055, 32'h0000_0066, 1'b0, 1'b1, 1'b0);
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        sb.delete();
        repeat (8) begin
            #1;
            chk("flush_quiet", sum_out_en, 1'b0);
            @(negedge clk);
        end
        send(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
